// File: rtl/seg_reader.sv
// -----------------------------------------------------------------------------
// seg_reader
//
// Captures an 8-digit, active-low seven-segment bus and decodes it into a
// 32-bit two's-complement integer. Digits are scanned one per clock, most
// significant (digit 7) first. Leading blanks are skipped, and an optional
// leading minus sign is accepted. A malformed display produces error=1 and
// value=0.
//
// Optional feature (macro SEG_READER_HEX_EN): adds the hex_mode input. When
// hex_mode is sampled high with start, the digits are read as an unsigned
// hexadecimal number that may use the letters A b C d E F. In this mode a
// minus sign is illegal.
//
// Ports
//   clk       in   1   clock; all state changes on posedge
//   rst       in   1   synchronous reset, active-low
//   start     in   1   capture segs and begin a decode (honoured only in IDLE)
//   segs      in  56   digit k at segs[7k+6:7k], bits {g,f,e,d,c,b,a}, active-low
//   hex_mode  in   1   (SEG_READER_HEX_EN only) decode as hexadecimal
//   busy      out  1   decode in progress (SCAN and FINISH)
//   done      out  1   one-cycle pulse; value/error were just updated
//   value     out 32   decoded result, held until the next done
//   error     out  1   illegal pattern flag, held until the next done
//
// Timing: a start accepted at edge N raises busy after edge N. Digits 7..0
// are consumed at edges N+1..N+8. The result is published at edge N+9, where
// done pulses and busy drops.
// -----------------------------------------------------------------------------
module seg_reader (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [55:0] segs,
`ifdef SEG_READER_HEX_EN
  input  logic        hex_mode,
`endif
  output logic        busy,
  output logic        done,
  output logic [31:0] value,
  output logic        error
);

  typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;
  typedef enum logic [1:0] {K_BLANK, K_MINUS, K_DIGIT, K_BAD} kind_t;

  state_t      state;
  logic [55:0] seg_q;     // snapshot taken at start; the live bus is ignored afterwards
  logic [2:0]  cnt;       // digit currently being scanned, counts 7 down to 0
  logic [31:0] acc;
  logic        sign;
  logic        seen_nb;   // a non-blank field (digit or minus) has been seen
  logic        seen_dig;  // at least one real digit has been seen
  logic        err;

`ifdef SEG_READER_HEX_EN
  logic        hex_q;
`endif

  logic [6:0]  cur;
  kind_t       kind;
  logic [3:0]  dval;
  logic [31:0] acc_next;

  // Classify the field selected by cnt.
  // NOTE: every always_comb output gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    cur  = 7'h7F;
    kind = K_BAD;
    dval = 4'd0;
    for (int k = 0; k < 8; k++) begin
      if (cnt == k[2:0]) cur = seg_q[7*k +: 7];
    end
    case (cur)
      7'h40: begin kind = K_DIGIT; dval = 4'd0; end
      7'h79: begin kind = K_DIGIT; dval = 4'd1; end
      7'h24: begin kind = K_DIGIT; dval = 4'd2; end
      7'h30: begin kind = K_DIGIT; dval = 4'd3; end
      7'h19: begin kind = K_DIGIT; dval = 4'd4; end
      7'h12: begin kind = K_DIGIT; dval = 4'd5; end
      7'h02: begin kind = K_DIGIT; dval = 4'd6; end
      7'h78: begin kind = K_DIGIT; dval = 4'd7; end
      7'h00: begin kind = K_DIGIT; dval = 4'd8; end
      7'h10: begin kind = K_DIGIT; dval = 4'd9; end
      7'h3F: kind = K_MINUS;
      7'h7F: kind = K_BLANK;
`ifdef SEG_READER_HEX_EN
      // Letters are digits only in hex mode. Otherwise they stay K_BAD.
      7'h08: if (hex_q) begin kind = K_DIGIT; dval = 4'd10; end
      7'h03: if (hex_q) begin kind = K_DIGIT; dval = 4'd11; end
      7'h46: if (hex_q) begin kind = K_DIGIT; dval = 4'd12; end
      7'h21: if (hex_q) begin kind = K_DIGIT; dval = 4'd13; end
      7'h06: if (hex_q) begin kind = K_DIGIT; dval = 4'd14; end
      7'h0E: if (hex_q) begin kind = K_DIGIT; dval = 4'd15; end
`endif
      default: kind = K_BAD;
    endcase
`ifdef SEG_READER_HEX_EN
    // A hex result is unsigned, so a minus sign is meaningless in that mode.
    if (hex_q && kind == K_MINUS) kind = K_BAD;
`endif
  end

  // Radix step built from shifts and adds: acc*10 = acc*8 + acc*2.
  always_comb begin
    acc_next = (acc << 3) + (acc << 1) + {28'd0, dval};
`ifdef SEG_READER_HEX_EN
    if (hex_q) acc_next = {acc[27:0], 4'd0} + {28'd0, dval};
`endif
  end

  // NOTE: all state is updated with non-blocking assignments. Each register
  // therefore sees the values from before this edge, whatever the order of the
  // statements.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      seg_q    <= '0;
      cnt      <= '0;
      acc      <= '0;
      sign     <= 1'b0;
      seen_nb  <= 1'b0;
      seen_dig <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      value    <= '0;
      error    <= 1'b0;
`ifdef SEG_READER_HEX_EN
      hex_q    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            seg_q    <= segs;
`ifdef SEG_READER_HEX_EN
            hex_q    <= hex_mode;
`endif
            cnt      <= 3'd7;
            acc      <= '0;
            sign     <= 1'b0;
            seen_nb  <= 1'b0;
            seen_dig <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b1;
            state    <= SCAN;
          end
        end

        SCAN: begin
          case (kind)
            // A blank is legal only before the first digit or minus.
            K_BLANK: if (seen_nb) err <= 1'b1;
            K_MINUS: begin
              if (seen_nb) err <= 1'b1;
              else begin
                sign    <= 1'b1;
                seen_nb <= 1'b1;
              end
            end
            K_DIGIT: begin
              acc      <= acc_next;
              seen_nb  <= 1'b1;
              seen_dig <= 1'b1;
            end
            default: err <= 1'b1;
          endcase
          cnt <= cnt - 3'd1;
          if (cnt == 3'd0) state <= FINISH;
        end

        FINISH: begin
          // A display with no digit at all covers two failures: every field
          // blank, and a minus sign with nothing after it.
          if (err || !seen_dig) begin
            value <= '0;
            error <= 1'b1;
          end else begin
            value <= sign ? (~acc + 32'd1) : acc;
            error <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_reader.sv
// -----------------------------------------------------------------------------
// tb_seg_reader
//
// Self-checking bench for seg_reader. Each decode pushes its expected
// {value, error} onto a scoreboard queue when start is driven. The entry is
// popped and compared when done is observed. Expected results come from a
// straightforward behavioural model that uses integer multiplication.
// -----------------------------------------------------------------------------
module tb_seg_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [55:0] segs = '0;
  logic        hex_mode = 1'b0;
  logic        busy, done, error;
  logic [31:0] value;

  seg_reader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .segs     (segs),
`ifdef SEG_READER_HEX_EN
    .hex_mode (hex_mode),
`endif
    .busy     (busy),
    .done     (done),
    .value    (value),
    .error    (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] value;
    logic        error;
  } exp_t;

  exp_t sb[$];
  int   assert_cnt = 0;
  int   fail_cnt   = 0;
  int   done_cnt   = 0;

  localparam logic [6:0] BL = 7'h7F;
  localparam logic [6:0] MN = 7'h3F;
  logic [6:0] dec_pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Reference model: walks the fields from digit 7 down to digit 0.
  function automatic exp_t model(input logic [55:0] s, input logic hx);
    exp_t        r;
    logic [31:0] acc = 0;
    bit          neg = 0, nb = 0, dig = 0, bad = 0;
    int          d;
    logic [6:0]  p;
    for (int k = 7; k >= 0; k--) begin
      p = s[7*k +: 7];
      d = -1;
      for (int j = 0; j < 10; j++) if (p == dec_pat[j]) d = j;
      if (hx) begin
        case (p)
          7'h08: d = 10;
          7'h03: d = 11;
          7'h46: d = 12;
          7'h21: d = 13;
          7'h06: d = 14;
          7'h0E: d = 15;
          default: ;
        endcase
      end
      if (d >= 0) begin
        acc = acc * (hx ? 32'd16 : 32'd10) + d;
        nb = 1; dig = 1;
      end else if (p == BL) begin
        if (nb) bad = 1;
      end else if (p == MN && !hx && !nb) begin
        neg = 1; nb = 1;
      end else begin
        bad = 1;
      end
    end
    if (bad || !dig) begin
      r.value = 0; r.error = 1;
    end else begin
      r.value = neg ? -acc : acc; r.error = 0;
    end
    return r;
  endfunction

  function automatic logic [55:0] pack8(input logic [6:0] d7, d6, d5, d4,
                                        d3, d2, d1, d0);
    return {d7, d6, d5, d4, d3, d2, d1, d0};
  endfunction

  // Drives start for exactly one edge, which is the acceptance edge N.
  task automatic start_pulse(input logic [55:0] s, input logic hx);
    @(negedge clk);
    segs = s; hex_mode = hx; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Called just after edge N. Waits up to 20 edges for done, then checks the
  // latency and the popped scoreboard entry, and that done lasts one cycle.
  task automatic wait_done(input string name);
    int   lat = 0;
    exp_t e;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin lat = i; break; end
    end
    start = 1'b0;
    assert_cnt++;
    if (lat != 9) begin
      fail_cnt++;
      $display("FAIL %s latency: got %0d edges (0 = timeout), need 9", name, lat);
    end
    if (lat != 0) begin
      if (sb.size() == 0) begin
        assert_cnt++; fail_cnt++;
        $display("FAIL %s scoreboard: done with empty queue", name);
      end else begin
        e = sb.pop_front();
        assert_cnt++;
        if (value !== e.value) begin
          fail_cnt++;
          $display("FAIL %s value: got %h, need %h", name, value, e.value);
        end
        assert_cnt++;
        if (error !== e.error) begin
          fail_cnt++;
          $display("FAIL %s error: got %b, need %b", name, error, e.error);
        end
      end
      assert_cnt++;
      if (busy !== 1'b0) begin
        fail_cnt++;
        $display("FAIL %s busy at done: got %b, need 0", name, busy);
      end
      @(posedge clk); #1;
      assert_cnt++;
      if (done !== 1'b0) begin
        fail_cnt++;
        $display("FAIL %s done width: got %b one cycle later, need 0", name, done);
      end
    end
  endtask

  task automatic run_decode(input string name, input logic [55:0] s, input logic hx);
    sb.push_back(model(s, hx));
    start_pulse(s, hx);
    assert_cnt++;
    if (busy !== 1'b1) begin
      fail_cnt++;
      $display("FAIL %s busy after start: got %b, need 1", name, busy);
    end
    wait_done(name);
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; segs = pack8(BL, BL, BL, BL, BL, BL, BL, 7'h79);
    repeat (3) @(posedge clk);
    #1;
    assert_cnt++;
    if ({busy, done, error} !== 3'b000) begin
      fail_cnt++;
      $display("FAIL reset flags: got busy/done/error=%b%b%b, need 000", busy, done, error);
    end
    assert_cnt++;
    if (value !== 32'd0) begin
      fail_cnt++;
      $display("FAIL reset value: got %h, need 0", value);
    end
    start = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    assert_cnt++;
    if (busy !== 1'b0) begin
      fail_cnt++;
      $display("FAIL reset idle busy: got %b, need 0", busy);
    end
  endtask

  task automatic test_decimal();
    logic [55:0] s;
    int          nbl;
    bit          neg;
    run_decode("dec_42", pack8(BL, BL, BL, BL, BL, BL, 7'h19, 7'h24), 1'b0);
    assert_cnt++;
    if (value !== 32'd42) begin
      fail_cnt++;
      $display("FAIL dec_42 literal: got %h, need 0000002a", value);
    end
    run_decode("dec_m123", pack8(BL, BL, BL, BL, MN, 7'h79, 7'h24, 7'h30), 1'b0);
    assert_cnt++;
    if (value !== 32'hFFFFFF85) begin
      fail_cnt++;
      $display("FAIL dec_m123 literal: got %h, need ffffff85", value);
    end
    run_decode("dec_lead0", pack8(7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h30, 7'h19), 1'b0);
    run_decode("dec_m1", pack8(MN, BL, BL, BL, BL, BL, BL, BL), 1'b0);
    run_decode("dec_minus_lsd", pack8(BL, BL, BL, BL, BL, BL, MN, 7'h78), 1'b0);
    // Random numbers with random leading blanks and an optional sign.
    for (int t = 0; t < 8; t++) begin
      nbl = $urandom_range(0, 3);
      neg = $urandom_range(0, 1) == 1;
      for (int k = 7; k >= 0; k--) begin
        if (7 - k < nbl) s[7*k +: 7] = BL;
        else if (7 - k == nbl && neg) s[7*k +: 7] = MN;
        else s[7*k +: 7] = dec_pat[$urandom_range(0, 9)];
      end
      run_decode("dec_rand", s, 1'b0);
    end
  endtask

  task automatic test_errors();
    run_decode("err_all_blank", {8{BL}}, 1'b0);
    run_decode("err_bad_pat", pack8(BL, BL, BL, BL, BL, BL, BL, 7'h0A), 1'b0);
    run_decode("err_blank_after_digit", pack8(BL, BL, BL, BL, BL, 7'h79, BL, 7'h24), 1'b0);
    run_decode("err_blank_after_minus", pack8(BL, BL, BL, BL, BL, MN, BL, 7'h24), 1'b0);
    run_decode("err_minus_mid", pack8(BL, BL, BL, BL, BL, 7'h79, MN, 7'h24), 1'b0);
    run_decode("err_double_minus", pack8(BL, BL, BL, BL, BL, MN, MN, 7'h24), 1'b0);
    run_decode("err_minus_only", pack8(BL, BL, BL, BL, BL, BL, BL, MN), 1'b0);
    run_decode("err_hex_in_dec", pack8(BL, BL, BL, BL, BL, BL, 7'h79, 7'h08), 1'b0);
    assert_cnt++;
    if (error !== 1'b1 || value !== 32'd0) begin
      fail_cnt++;
      $display("FAIL err_hex_in_dec literal: got error=%b value=%h, need 1/0", error, value);
    end
  endtask

  task automatic test_reset_mid_scan();
    int dc;
    run_decode("pre_abort", pack8(BL, BL, BL, BL, BL, BL, 7'h19, 7'h24), 1'b0);
    start_pulse(pack8(BL, BL, BL, BL, BL, BL, 7'h79, 7'h79), 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    dc = done_cnt;
    @(posedge clk); #1;
    assert_cnt++;
    if ({busy, done, error} !== 3'b000 || value !== 32'd0) begin
      fail_cnt++;
      $display("FAIL abort state: got busy/done/error=%b%b%b value=%h, need 000/0",
               busy, done, error, value);
    end
    rst = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    assert_cnt++;
    if (done_cnt !== dc) begin
      fail_cnt++;
      $display("FAIL abort no_done: got %0d done pulses, need 0", done_cnt - dc);
    end
    run_decode("after_abort_9s", {8{7'h10}}, 1'b0);
    assert_cnt++;
    if (value !== 32'h05F5E0FF) begin
      fail_cnt++;
      $display("FAIL after_abort_9s literal: got %h, need 05f5e0ff", value);
    end
  endtask

  // Holds start high through SCAN and FINISH with a different segs value.
  // Only the first request is decoded, which also shows that segs is latched.
  task automatic test_ignore_start();
    int          dc;
    logic [55:0] a = pack8(BL, BL, BL, BL, BL, 7'h02, 7'h12, 7'h19);
    dc = done_cnt;
    sb.push_back(model(a, 1'b0));
    start_pulse(a, 1'b0);
    @(negedge clk);
    segs = {8{7'h00}}; start = 1'b1;
    wait_done("ignore_start");
    repeat (15) @(posedge clk);
    #1;
    assert_cnt++;
    if (done_cnt !== dc + 1) begin
      fail_cnt++;
      $display("FAIL ignore_start pulses: got %0d, need 1", done_cnt - dc);
    end
  endtask

  task automatic test_back_to_back();
    run_decode("b2b_0", pack8(BL, BL, BL, BL, BL, BL, BL, 7'h78), 1'b0);
    run_decode("b2b_1", pack8(MN, 7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30), 1'b0);
    run_decode("b2b_2", pack8(7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00), 1'b0);
  endtask

`ifdef SEG_READER_HEX_EN
  task automatic test_hex();
    run_decode("hex_abcdef01",
               pack8(7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h40, 7'h79), 1'b1);
    assert_cnt++;
    if (value !== 32'hABCDEF01 || error !== 1'b0) begin
      fail_cnt++;
      $display("FAIL hex_abcdef01 literal: got %h/%b, need abcdef01/0", value, error);
    end
    run_decode("hex_minus", pack8(BL, BL, BL, BL, BL, BL, MN, 7'h08), 1'b1);
    run_decode("hex_short", pack8(BL, BL, BL, BL, BL, 7'h0E, 7'h10, 7'h46), 1'b1);
    run_decode("hex_off_letters", pack8(BL, BL, BL, BL, BL, BL, 7'h03, 7'h21), 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_decimal();
    test_errors();
    test_reset_mid_scan();
    test_ignore_start();
    test_back_to_back();
`ifdef SEG_READER_HEX_EN
    test_hex();
`endif
    assert_cnt++;
    if (sb.size() != 0) begin
      fail_cnt++;
      $display("FAIL scoreboard drain: got %0d left, need 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
